elastic_pipe_buf: RTL and testbench

- Parametrised elastic pipeline stage: successor to the 2-entry fetch/ID skid stage, placed between any two core stages (IF->ID, ID->EX, EX->LSU).
- Carries an opaque DATA_W payload through a DEPTH-entry in-order buffer with valid/ready handshakes on both sides.
- Adds a synchronous flush (branch redirect / exception kill), an occupancy output and a programmable bubble value.
- All outputs are registered. There is no combinational path from any input to any output.

---
 rtl/elastic_pipe_buf.sv | 114 +++++++++++
 tb/tb_elastic_pipe_buf.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_buf.sv
// -----------------------------------------------------------------------------
// elastic_pipe_buf
//
// Purpose:
//   Elastic pipeline stage that sits between two core stages (IF->ID, ID->EX,
//   EX->LSU). It carries an opaque payload through a DEPTH-entry in-order
//   circular buffer with valid/ready handshakes on both sides. It adds a
//   synchronous flush for branch redirects and exception kills, an occupancy
//   output, and a programmable bubble value. Every output is driven from a
//   register, so no input reaches an output through combinational logic.
//
// Parameters:
//   DATA_W      payload width in bits
//   DEPTH       entry count (power of two, >= 2)
//   BUBBLE_DATA value shown on o_data after reset or flush
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (takes priority over flush)
//   flush    in   synchronous kill of all held entries
//   i_valid  in   upstream payload valid
//   i_ready  out  buffer can accept (registered)
//   i_data   in   upstream payload
//   o_valid  out  head entry valid (registered)
//   o_ready  in   downstream accepts
//   o_data   out  head payload (registered)
//   o_count  out  number of entries currently held
// -----------------------------------------------------------------------------
module elastic_pipe_buf #(
  parameter int unsigned        DATA_W      = 96,
  parameter int unsigned        DEPTH       = 2,
  parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [DATA_W-1:0]            i_data,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [DATA_W-1:0]            o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              i_ready_q;
  logic              o_valid_q;
  logic [DATA_W-1:0] o_data_q, o_data_d;

  logic insert;
  logic remove;

  assign insert = i_valid & i_ready_q;
  assign remove = o_valid_q & o_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(insert);
    rd_ptr_d = rd_ptr_q + PTR_W'(remove);
    count_d  = count_q + CNT_W'(insert) - CNT_W'(remove);
    // The output register is preloaded with whatever will be the head after
    // this edge. When the buffer drains it keeps the last removed payload.
    o_data_d = o_data_q;
    if (count_d != '0) begin
      // The new head is the entry being written this cycle exactly when the
      // buffer is (or becomes) otherwise empty: bypass it from i_data.
      if (insert && (wr_ptr_q == rd_ptr_d)) begin
        o_data_d = i_data;
      end else begin
        o_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Storage needs no reset: pointers and count alone define which slots hold
  // live data.
  always_ff @(posedge clk) begin
    if (insert) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      o_data_q  <= BUBBLE_DATA;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      i_ready_q <= (count_d != FULL_CNT);
      o_valid_q <= (count_d != '0);
      o_data_q  <= o_data_d;
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_elastic_pipe_buf.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe_buf
//
// Two instances (DEPTH=2 and DEPTH=4) share clk and rst. Each has a
// negedge scoreboard: payloads are queued when an insert is driven and
// compared against o_data while the entry is the head and when it is removed.
// The queue length is the expected occupancy. A linear directed sequence in
// one initial block drives the scenarios and adds targeted checks.
// -----------------------------------------------------------------------------
module tb_elastic_pipe_buf;

  localparam int            DW  = 16;
  localparam logic [DW-1:0] BUB = 16'hB0B0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          flush2, i_valid2, i_ready2, o_valid2, o_ready2;
  logic [DW-1:0] i_data2, o_data2;
  logic [1:0]    o_count2;

  logic          flush4, i_valid4, i_ready4, o_valid4, o_ready4;
  logic [DW-1:0] i_data4, o_data4;
  logic [2:0]    o_count4;

  elastic_pipe_buf #(.DATA_W(DW), .DEPTH(2), .BUBBLE_DATA(BUB)) dut2 (
    .clk(clk), .rst(rst), .flush(flush2),
    .i_valid(i_valid2), .i_ready(i_ready2), .i_data(i_data2),
    .o_valid(o_valid2), .o_ready(o_ready2), .o_data(o_data2),
    .o_count(o_count2)
  );

  elastic_pipe_buf #(.DATA_W(DW), .DEPTH(4), .BUBBLE_DATA(BUB)) dut4 (
    .clk(clk), .rst(rst), .flush(flush4),
    .i_valid(i_valid4), .i_ready(i_ready4), .i_data(i_data4),
    .o_valid(o_valid4), .o_ready(o_ready4), .o_data(o_data4),
    .o_count(o_count4)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scoreboard, DEPTH=2 ----------------
  logic [DW-1:0] q2[$];
  logic [DW-1:0] hold2_m = BUB;
  bit            ins2, rem2;

  always @(negedge clk) if (mon_en) begin
    check("count2", 32'(o_count2), 32'(q2.size()));
    check("count2_max", 32'(o_count2 <= 2'd2), 32'd1);
    check("ovalid2", 32'(o_valid2), 32'(q2.size() != 0));
    check("iready2", 32'(i_ready2), 32'(q2.size() != 2));
    if (q2.size() == 0) check("idle_data2", 32'(o_data2), 32'(hold2_m));
    else                check("head_data2", 32'(o_data2), 32'(q2[0]));
    ins2 = i_valid2 && (q2.size() != 2);
    rem2 = o_ready2 && (q2.size() != 0);
    if (rst) begin
      q2.delete();
      hold2_m = BUB;
    end else begin
      if (rem2) hold2_m = q2.pop_front();
      if (flush2) begin
        q2.delete();
        hold2_m = BUB;
      end else if (ins2) begin
        q2.push_back(i_data2);
      end
    end
  end

  // ---------------- scoreboard, DEPTH=4 ----------------
  logic [DW-1:0] q4[$];
  logic [DW-1:0] hold4_m = BUB;
  bit            ins4, rem4;

  always @(negedge clk) if (mon_en) begin
    check("count4", 32'(o_count4), 32'(q4.size()));
    check("count4_max", 32'(o_count4 <= 3'd4), 32'd1);
    check("ovalid4", 32'(o_valid4), 32'(q4.size() != 0));
    check("iready4", 32'(i_ready4), 32'(q4.size() != 4));
    if (q4.size() == 0) check("idle_data4", 32'(o_data4), 32'(hold4_m));
    else                check("head_data4", 32'(o_data4), 32'(q4[0]));
    ins4 = i_valid4 && (q4.size() != 4);
    rem4 = o_ready4 && (q4.size() != 0);
    if (rst) begin
      q4.delete();
      hold4_m = BUB;
    end else begin
      if (rem4) hold4_m = q4.pop_front();
      if (flush4) begin
        q4.delete();
        hold4_m = BUB;
      end else if (ins4) begin
        q4.push_back(i_data4);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit acc;
    int guard;

    rst = 1'b1;
    flush2 = 1'b0; i_valid2 = 1'b0; i_data2 = '0; o_ready2 = 1'b0;
    flush4 = 1'b0; i_valid4 = 1'b0; i_data4 = '0; o_ready4 = 1'b0;
    step(2);
    check("rst_ovalid2", 32'(o_valid2), 32'd0);
    check("rst_iready2", 32'(i_ready2), 32'd1);
    check("rst_count2",  32'(o_count2), 32'd0);
    check("rst_data2",   32'(o_data2),  32'(BUB));
    check("rst_ovalid4", 32'(o_valid4), 32'd0);
    check("rst_iready4", 32'(i_ready4), 32'd1);
    check("rst_count4",  32'(o_count4), 32'd0);
    check("rst_data4",   32'(o_data4),  32'(BUB));
    rst = 1'b0;
    mon_en = 1'b1;
    step(1);

    // Streaming through DEPTH=2: one-cycle latency, count stays 1
    o_ready2 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      i_valid2 = 1'b1;
      i_data2  = DW'(i);
      step(1);
      check("stream_data", 32'(o_data2), 32'(i));
      check("stream_count", 32'(o_count2), 32'd1);
      check("stream_iready", 32'(i_ready2), 32'd1);
    end
    i_valid2 = 1'b0;
    step(2);

    // Back-pressure on DEPTH=4
    o_ready4 = 1'b0;
    i_valid4 = 1'b1;
    i_data4 = 16'h000A; step(1);
    i_data4 = 16'h000B; step(1);
    i_data4 = 16'h000C; step(1);
    i_data4 = 16'h000D; step(1);
    check("bp_full_iready", 32'(i_ready4), 32'd0);
    check("bp_full_count", 32'(o_count4), 32'd4);
    i_data4 = 16'h000E; step(2);
    check("bp_hold_count", 32'(o_count4), 32'd4);
    check("bp_hold_head", 32'(o_data4), 32'h000A);
    o_ready4 = 1'b1;
    step(1);
    check("bp_iready_back", 32'(i_ready4), 32'd1);
    check("bp_count_after_rm", 32'(o_count4), 32'd3);
    step(1);
    i_valid4 = 1'b0;
    step(5);
    check("bp_drained", 32'(o_count4), 32'd0);

    // Full DEPTH=2 with simultaneous traffic
    o_ready2 = 1'b0;
    i_valid2 = 1'b1;
    i_data2 = 16'h0021; step(1);
    i_data2 = 16'h0022; step(1);
    i_valid2 = 1'b0;
    check("full2_count", 32'(o_count2), 32'd2);
    check("full2_iready", 32'(i_ready2), 32'd0);
    o_ready2 = 1'b1;
    step(1);
    o_ready2 = 1'b0;
    check("full2_rm_count", 32'(o_count2), 32'd1);
    check("full2_rm_iready", 32'(i_ready2), 32'd1);
    i_valid2 = 1'b1; i_data2 = 16'h0023; o_ready2 = 1'b1;
    step(1);
    i_valid2 = 1'b0;
    check("simul_count", 32'(o_count2), 32'd1);
    check("simul_head", 32'(o_data2), 32'h0023);
    step(2);
    check("simul_drained", 32'(o_count2), 32'd0);

    // Flush mid-stream on DEPTH=4
    o_ready4 = 1'b0;
    i_valid4 = 1'b1;
    i_data4 = 16'h0031; step(1);
    i_data4 = 16'h0032; step(1);
    i_data4 = 16'h0033; step(1);
    check("pre_flush_count", 32'(o_count4), 32'd3);
    flush4 = 1'b1; i_data4 = 16'h0055;
    step(1);
    flush4 = 1'b0; i_valid4 = 1'b0;
    check("flush_ovalid", 32'(o_valid4), 32'd0);
    check("flush_count", 32'(o_count4), 32'd0);
    check("flush_iready", 32'(i_ready4), 32'd1);
    check("flush_data", 32'(o_data4), 32'(BUB));
    o_ready4 = 1'b1;
    step(3);
    check("flush_no_55", 32'(o_valid4), 32'd0);
    // Multi-cycle flush with inserts attempted
    flush4 = 1'b1; i_valid4 = 1'b1; i_data4 = 16'h0056;
    step(1);
    check("flush_n1_count", 32'(o_count4), 32'd0);
    step(1);
    check("flush_n2_count", 32'(o_count4), 32'd0);
    flush4 = 1'b0; i_data4 = 16'h0066;
    step(1);
    i_valid4 = 1'b0;
    check("post_flush_data", 32'(o_data4), 32'h0066);
    step(2);

    // Pointer wrap with random downstream stalls
    for (int k = 0; k < 9; k++) begin
      i_valid4 = 1'b1;
      i_data4  = DW'(16'h0040 + k);
      guard = 0;
      do begin
        o_ready4 = 1'($urandom_range(0, 1));
        acc = i_ready4;
        step(1);
        guard++;
      end while (!acc && guard < 50);
      check("wrap_accept", 32'(acc), 32'd1);
    end
    i_valid4 = 1'b0;
    o_ready4 = 1'b1;
    guard = 0;
    while (o_count4 != 3'd0 && guard < 20) begin
      step(1);
      guard++;
    end
    check("wrap_drain", 32'(o_count4), 32'd0);

    // Reset with three entries held
    o_ready4 = 1'b0;
    i_valid4 = 1'b1;
    i_data4 = 16'h0071; step(1);
    i_data4 = 16'h0072; step(1);
    i_data4 = 16'h0073; step(1);
    i_valid4 = 1'b0;
    check("pre_rst_count", 32'(o_count4), 32'd3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mrst_ovalid", 32'(o_valid4), 32'd0);
    check("mrst_iready", 32'(i_ready4), 32'd1);
    check("mrst_count", 32'(o_count4), 32'd0);
    check("mrst_data", 32'(o_data4), 32'(BUB));
    step(2);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
